// File: rtl/jesd204b_rx_pkg.sv
// Shared constants and helpers for the JESD204B receive transport layer.
// Each slot is an N'=16-bit word split MSB-first into data, control and tail.
package jesd204b_rx_pkg;

  localparam int N_PRIME = 16;

  function automatic int frame_octets(input int m, input int s);
    return 2 * m * s;
  endfunction

  function automatic int frame_beats(input int f, input int po);
    return f / po;
  endfunction

  function automatic logic [15:0] slot_data(input logic [15:0] w, input int n);
    return w >> (N_PRIME - n);
  endfunction

  function automatic logic [15:0] slot_ctrl(input logic [15:0] w, input int n, input int cs);
    logic [15:0] mask;
    mask = (16'd1 << cs) - 16'd1;
    return (w >> (N_PRIME - n - cs)) & mask;
  endfunction

  // Tail mask collapses to zero when N+CS fills the whole word.
  function automatic logic [15:0] slot_tail(input logic [15:0] w, input int n, input int cs);
    return w & ((16'd1 << (N_PRIME - n - cs)) - 16'd1);
  endfunction

endpackage

// File: rtl/jesd204b_rx_frame_unpack.sv
// Combinational slicer: assembled frame octets to per-slot samples, control bits
// and an any-tail-nonzero flag. Octet 0 sits in the least significant byte.
module jesd204b_rx_frame_unpack
  import jesd204b_rx_pkg::*;
#(
  parameter int NUM_CONVERTERS    = 2,
  parameter int SAMPLES_PER_FRAME = 1,
  parameter int CONV_RESOLUTION   = 14,
  parameter int CONTROL_BITS      = 2,
  localparam int F     = 2 * NUM_CONVERTERS * SAMPLES_PER_FRAME,
  localparam int SLOTS = NUM_CONVERTERS * SAMPLES_PER_FRAME,
  localparam int CSW   = (CONTROL_BITS > 0) ? CONTROL_BITS : 1
) (
  input  logic [F*8-1:0]               frame,
  output logic [SLOTS*CONV_RESOLUTION-1:0] sample,
  output logic [SLOTS*CSW-1:0]         ctrl,
  output logic                         tail_nz
);

  logic [SLOTS-1:0] tail_bits;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    logic [15:0] word;
    assign word = {frame[2*gi*8 +: 8], frame[(2*gi+1)*8 +: 8]};
    assign sample[gi*CONV_RESOLUTION +: CONV_RESOLUTION] =
      CONV_RESOLUTION'(slot_data(word, CONV_RESOLUTION));
    if (CONTROL_BITS > 0) begin : g_cs
      assign ctrl[gi*CSW +: CSW] = CSW'(slot_ctrl(word, CONV_RESOLUTION, CONTROL_BITS));
    end else begin : g_no_cs
      assign ctrl[gi*CSW +: CSW] = '0;
    end
    assign tail_bits[gi] = |slot_tail(word, CONV_RESOLUTION, CONTROL_BITS);
  end

  assign tail_nz = |tail_bits;

endmodule

// File: rtl/jesd204b_rx_deframer.sv
// Single-lane JESD204B transport deframer: assembles F-octet frames from
// PARALLEL_OCTETS-wide beats, unpacks them and tracks multiframe position.
module jesd204b_rx_deframer
  import jesd204b_rx_pkg::*;
#(
  parameter int PARALLEL_OCTETS       = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int NUM_CONVERTERS        = 2,
  parameter int SAMPLES_PER_FRAME     = 1,
  parameter int CONV_RESOLUTION       = 14,
  parameter int CONTROL_BITS          = 2,
  parameter int FRAMES_PER_MULTIFRAME = 32,
  localparam int SLOTS = NUM_CONVERTERS * SAMPLES_PER_FRAME,
  localparam int CSW   = (CONTROL_BITS > 0) ? CONTROL_BITS : 1,
  localparam int CNT_W = (FRAMES_PER_MULTIFRAME > 1) ? $clog2(FRAMES_PER_MULTIFRAME) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [DATA_WIDTH-1:0]            lane_data_i,
  input  logic                             lane_valid_i,
  input  logic                             err_clr_i,
  output logic [SLOTS*CONV_RESOLUTION-1:0] sample_o,
  output logic [SLOTS*CSW-1:0]             ctrl_o,
  output logic                             frame_valid_o,
  output logic                             mf_start_o,
  output logic [CNT_W-1:0]                 frame_cnt_o,
  output logic                             tail_err_o,
  output logic                             drop_err_o
);

  localparam int F      = frame_octets(NUM_CONVERTERS, SAMPLES_PER_FRAME);
  localparam int BEATS  = frame_beats(F, PARALLEL_OCTETS);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (F % PARALLEL_OCTETS != 0) begin : g_bad_f
    $error("frame size must be a multiple of PARALLEL_OCTETS");
  end
  if (CONV_RESOLUTION + CONTROL_BITS > N_PRIME) begin : g_bad_n
    $error("N + CS must not exceed 16");
  end
  if (DATA_WIDTH != 8 * PARALLEL_OCTETS) begin : g_bad_w
    $error("DATA_WIDTH must equal 8*PARALLEL_OCTETS");
  end

  logic [BEAT_W-1:0]            beat_cnt_reg;
  logic [CNT_W-1:0]             frame_cnt_reg;
  logic [F*8-1:0]               frame_reg;
  logic [F*8-1:0]               frame_next;
  logic [SLOTS*CONV_RESOLUTION-1:0] unpack_sample;
  logic [SLOTS*CSW-1:0]         unpack_ctrl;
  logic                         unpack_tail_nz;
  logic                         frame_done;
  logic                         tail_set;
  logic                         drop_set;

  // The incoming beat is merged combinationally so the frame unpacks on its last beat.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign frame_next[gi*DATA_WIDTH +: DATA_WIDTH] =
      (beat_cnt_reg == BEAT_W'(gi)) ? lane_data_i : frame_reg[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  jesd204b_rx_frame_unpack #(
    .NUM_CONVERTERS    (NUM_CONVERTERS),
    .SAMPLES_PER_FRAME (SAMPLES_PER_FRAME),
    .CONV_RESOLUTION   (CONV_RESOLUTION),
    .CONTROL_BITS      (CONTROL_BITS)
  ) u_unpack (
    .frame   (frame_next),
    .sample  (unpack_sample),
    .ctrl    (unpack_ctrl),
    .tail_nz (unpack_tail_nz)
  );

  assign frame_done = lane_valid_i && (beat_cnt_reg == BEAT_W'(BEATS - 1));
  assign tail_set   = frame_done && unpack_tail_nz;
  assign drop_set   = !lane_valid_i && (beat_cnt_reg != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      frame_reg     <= '0;
      sample_o      <= '0;
      ctrl_o        <= '0;
      frame_valid_o <= 1'b0;
      mf_start_o    <= 1'b0;
      frame_cnt_o   <= '0;
      tail_err_o    <= 1'b0;
      drop_err_o    <= 1'b0;
    end else begin
      frame_valid_o <= frame_done;
      mf_start_o    <= frame_done && (frame_cnt_reg == '0);
      if (lane_valid_i) begin
        frame_reg    <= frame_next;
        beat_cnt_reg <= frame_done ? '0 : beat_cnt_reg + 1'b1;
        if (frame_done) begin
          frame_cnt_reg <= (frame_cnt_reg == CNT_W'(FRAMES_PER_MULTIFRAME - 1)) ?
                           '0 : frame_cnt_reg + 1'b1;
          sample_o      <= unpack_sample;
          ctrl_o        <= unpack_ctrl;
          frame_cnt_o   <= frame_cnt_reg;
        end
      end else begin
        // Link dropped: next valid beat restarts at octet 0 of a multiframe.
        beat_cnt_reg  <= '0;
        frame_cnt_reg <= '0;
      end
      tail_err_o <= tail_set || (tail_err_o && !err_clr_i);
      drop_err_o <= drop_set || (drop_err_o && !err_clr_i);
    end
  end

endmodule

// File: tb/tb_jesd204b_rx_deframer.sv
// Three deframer configurations driven from a shared lane, each checked every
// cycle against an octet-queue reference model of the transport layer.
module tb_jesd204b_rx_deframer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lane_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] lane_data = '0;

  always #5 clk = ~clk;

  // A: defaults (F=4); B: M=2 S=2 (F=8); C: N=12 CS=2 (F=4, 2 tail bits)
  logic [27:0] sample_a; logic [3:0] ctrl_a; logic fv_a, mf_a, tail_a, drop_a; logic [4:0] cnt_a;
  logic [55:0] sample_b; logic [7:0] ctrl_b; logic fv_b, mf_b, tail_b, drop_b; logic [4:0] cnt_b;
  logic [23:0] sample_c; logic [3:0] ctrl_c; logic fv_c, mf_c, tail_c, drop_c; logic [4:0] cnt_c;

  jesd204b_rx_deframer dut_a (
    .clk_i(clk), .rst_i(rst), .lane_data_i(lane_data), .lane_valid_i(lane_valid),
    .err_clr_i(err_clr), .sample_o(sample_a), .ctrl_o(ctrl_a), .frame_valid_o(fv_a),
    .mf_start_o(mf_a), .frame_cnt_o(cnt_a), .tail_err_o(tail_a), .drop_err_o(drop_a));

  jesd204b_rx_deframer #(.SAMPLES_PER_FRAME(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .lane_data_i(lane_data), .lane_valid_i(lane_valid),
    .err_clr_i(err_clr), .sample_o(sample_b), .ctrl_o(ctrl_b), .frame_valid_o(fv_b),
    .mf_start_o(mf_b), .frame_cnt_o(cnt_b), .tail_err_o(tail_b), .drop_err_o(drop_b));

  jesd204b_rx_deframer #(.CONV_RESOLUTION(12)) dut_c (
    .clk_i(clk), .rst_i(rst), .lane_data_i(lane_data), .lane_valid_i(lane_valid),
    .err_clr_i(err_clr), .sample_o(sample_c), .ctrl_o(ctrl_c), .frame_valid_o(fv_c),
    .mf_start_o(mf_c), .frame_cnt_o(cnt_c), .tail_err_o(tail_c), .drop_err_o(drop_c));

  int tests = 0;
  int fails = 0;

  int cfg_m [3] = '{2, 2, 2};
  int cfg_s [3] = '{1, 2, 1};
  int cfg_n [3] = '{14, 14, 12};
  localparam int CS = 2;
  localparam int K  = 32;

  int          octs [3][16];
  int          fill [3];
  int          fidx [3];
  logic [63:0] e_sample [3];
  logic [63:0] e_ctrl [3];
  logic [63:0] e_fv [3];
  logic [63:0] e_mf [3];
  logic [63:0] e_cnt [3];
  logic [63:0] e_tail [3];
  logic [63:0] e_drop [3];

  int pulses_a = 0;
  int mfs_a    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: octets accumulate in arrival order; a full queue is one frame.
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int  f;
      bit  tail_set;
      bit  drop_set;
      f        = 2 * cfg_m[d] * cfg_s[d];
      tail_set = 1'b0;
      drop_set = 1'b0;
      e_fv[d]  = '0;
      e_mf[d]  = '0;
      if (rst) begin
        fill[d] = 0; fidx[d] = 0;
        e_sample[d] = '0; e_ctrl[d] = '0; e_cnt[d] = '0; e_tail[d] = '0; e_drop[d] = '0;
      end else begin
        if (lane_valid) begin
          for (int j = 0; j < 4; j++) begin
            octs[d][fill[d]] = int'(lane_data[j*8 +: 8]);
            fill[d]++;
          end
          if (fill[d] == f) begin
            e_sample[d] = '0;
            e_ctrl[d]   = '0;
            for (int k = 0; k < f / 2; k++) begin
              int w, n, tb, data, ctl, tl;
              n    = cfg_n[d];
              tb   = 16 - n - CS;
              w    = octs[d][2*k] * 256 + octs[d][2*k+1];
              data = w / (1 << (16 - n));
              ctl  = (w / (1 << tb)) % (1 << CS);
              tl   = w % (1 << tb);
              e_sample[d] = e_sample[d] | (64'(data) << (k * n));
              e_ctrl[d]   = e_ctrl[d] | (64'(ctl) << (k * CS));
              if (tl != 0) tail_set = 1'b1;
            end
            e_fv[d]  = 64'd1;
            e_mf[d]  = (fidx[d] == 0) ? 64'd1 : 64'd0;
            e_cnt[d] = 64'(fidx[d]);
            fidx[d]  = (fidx[d] + 1) % K;
            fill[d]  = 0;
          end
        end else begin
          drop_set = (fill[d] != 0);
          fill[d]  = 0;
          fidx[d]  = 0;
        end
        e_tail[d] = (tail_set || (e_tail[d] != 0 && !err_clr)) ? 64'd1 : 64'd0;
        e_drop[d] = (drop_set || (e_drop[d] != 0 && !err_clr)) ? 64'd1 : 64'd0;
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] a_s [3], a_c [3], a_fv [3], a_mf [3], a_cnt [3], a_t [3], a_d [3];
    a_s   = '{64'(sample_a), 64'(sample_b), 64'(sample_c)};
    a_c   = '{64'(ctrl_a), 64'(ctrl_b), 64'(ctrl_c)};
    a_fv  = '{64'(fv_a), 64'(fv_b), 64'(fv_c)};
    a_mf  = '{64'(mf_a), 64'(mf_b), 64'(mf_c)};
    a_cnt = '{64'(cnt_a), 64'(cnt_b), 64'(cnt_c)};
    a_t   = '{64'(tail_a), 64'(tail_b), 64'(tail_c)};
    a_d   = '{64'(drop_a), 64'(drop_b), 64'(drop_c)};
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d frame_valid", d), a_fv[d], e_fv[d]);
      check($sformatf("dut%0d sample", d), a_s[d], e_sample[d]);
      check($sformatf("dut%0d ctrl", d), a_c[d], e_ctrl[d]);
      check($sformatf("dut%0d mf_start", d), a_mf[d], e_mf[d]);
      check($sformatf("dut%0d frame_cnt", d), a_cnt[d], e_cnt[d]);
      check($sformatf("dut%0d tail_err", d), a_t[d], e_tail[d]);
      check($sformatf("dut%0d drop_err", d), a_d[d], e_drop[d]);
    end
    if (fv_a) pulses_a++;
    if (fv_a && mf_a) mfs_a++;
  endtask

  task automatic step(input bit v, input logic [31:0] data, input bit clr, input bit r);
    lane_valid = v;
    lane_data  = data;
    err_clr    = clr;
    rst        = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] beat(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    check("reset frame_valid", 64'(fv_a), 64'd0);
    check("reset sample", 64'(sample_b), 64'd0);

    // Worked example: bytes 12 34 AB CD
    step(1, beat(8'h12, 8'h34, 8'hAB, 8'hCD), 0, 0);
    check("ex sample", 64'(sample_a), 64'({14'h2AF3, 14'h048D}));
    check("ex ctrl", 64'(ctrl_a), 64'(4'b0100));
    check("ex mf_start", 64'(mf_a), 64'd1);
    check("ex frame_cnt", 64'(cnt_a), 64'd0);
    check("ex c tail", 64'(tail_c), 64'd1);

    // B is mid-frame here; A is on a boundary
    step(0, '0, 0, 0);
    check("drop b", 64'(drop_b), 64'd1);
    check("no drop a", 64'(drop_a), 64'd0);
    step(0, '0, 1, 0);

    pulses_a = 0;
    mfs_a    = 0;
    for (int i = 0; i < 70; i++) step(1, $urandom, 0, 0);
    step(0, '0, 0, 0);
    check("70 beats pulses", 64'(pulses_a), 64'd70);
    check("70 beats mf_starts", 64'(mfs_a), 64'd3);

    // Drop after one beat on B, then restart
    step(1, $urandom, 1, 0);
    step(0, '0, 0, 0);
    check("drop b again", 64'(drop_b), 64'd1);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 0);
    check("b restart pulse", 64'(fv_b), 64'd1);
    check("b restart cnt", 64'(cnt_b), 64'd0);
    step(0, '0, 1, 0);
    check("drop b cleared", 64'(drop_b), 64'd0);

    // Tail error on C with word 0x1235, then set wins over clear
    step(0, '0, 1, 0);
    step(1, beat(8'h12, 8'h35, 8'h00, 8'h00), 0, 0);
    check("c tail set", 64'(tail_c), 64'd1);
    step(0, '0, 0, 0);
    check("c tail sticky", 64'(tail_c), 64'd1);
    step(1, beat(8'h12, 8'h35, 8'h00, 8'h00), 1, 0);
    check("c tail set wins", 64'(tail_c), 64'd1);

    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0,
           $urandom_range(0, 39) == 0);

    // Reset in the middle of a frame
    step(0, '0, 0, 0);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 1);
    check("mid reset fv", 64'(fv_a), 64'd0);
    check("mid reset sample", 64'(sample_a), 64'd0);
    step(0, '0, 0, 0);
    check("no stale pulse", 64'(fv_b), 64'd0);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 0);
    check("post reset b cnt", 64'(cnt_b), 64'd0);
    check("post reset b mf", 64'(mf_b), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
